// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-3 priority distribution demux.
package demux_pkg;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_1    = 2'd1,
    DEST_2    = 2'd2,
    DEST_3    = 2'd3
  } dest_e;

  localparam logic [7:0]  DROP_MAX      = 8'd255;
  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage : demux_pkg

// File: rtl/demux_dist_if.sv
// Producer-side stream and the three consumer-side buffered outputs.
interface demux_dist_if #(parameter int unsigned WIDTH = 4);

  logic [WIDTH-1:0] ip;
  logic             ip_valid;
  logic             ip_ready;
  logic             sel1;
  logic             sel2;
  logic             sel3;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] op3;
  logic             op1_valid;
  logic             op2_valid;
  logic             op3_valid;
  logic             op1_ready;
  logic             op2_ready;
  logic             op3_ready;

  // Environment side: drives the input stream and the consumer readies.
  modport master (
    output ip, ip_valid, sel1, sel2, sel3, op1_ready, op2_ready, op3_ready,
    input  ip_ready, op1, op2, op3, op1_valid, op2_valid, op3_valid
  );

  // Demux side.
  modport slave (
    input  ip, ip_valid, sel1, sel2, sel3, op1_ready, op2_ready, op3_ready,
    output ip_ready, op1, op2, op3, op1_valid, op2_valid, op3_valid
  );

endinterface : demux_dist_if

// File: rtl/out_slot.sv
// One-entry output buffer: a load wins over a drain on the same edge, so a
// slot whose consumer is always ready sustains one word per cycle.
module out_slot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  // Load new word, otherwise clear valid once the consumer takes the word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= data_in;
      valid_out <= 1'b1;
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule : out_slot

// File: rtl/demux_dist.sv
// Registered 1-to-3 priority demultiplexer with per-output one-entry buffers
// and a saturating counter of words accepted with no select asserted.
module demux_dist
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  demux_dist_if.slave  bus,
  output logic [7:0]   drop_count
);

  dest_e dest;
  logic  accept;

  // Priority decode of the destination selects (sel1 > sel2 > sel3).
  always_comb begin
    dest = DEST_NONE;
    if (bus.sel1)      dest = DEST_1;
    else if (bus.sel2) dest = DEST_2;
    else if (bus.sel3) dest = DEST_3;
  end

  // Ready depends only on the selected slot, never on ip_valid.
  always_comb begin
    bus.ip_ready = 1'b1;
    case (dest)
      DEST_1:  bus.ip_ready = !bus.op1_valid || bus.op1_ready;
      DEST_2:  bus.ip_ready = !bus.op2_valid || bus.op2_ready;
      DEST_3:  bus.ip_ready = !bus.op3_valid || bus.op3_ready;
      default: bus.ip_ready = 1'b1;
    endcase
  end

  assign accept = bus.ip_valid && bus.ip_ready;

  out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clock     (clock),
    .reset     (reset),
    .load      (accept && (dest == DEST_1)),
    .data_in   (bus.ip),
    .ready_in  (bus.op1_ready),
    .data_out  (bus.op1),
    .valid_out (bus.op1_valid)
  );

  out_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clock     (clock),
    .reset     (reset),
    .load      (accept && (dest == DEST_2)),
    .data_in   (bus.ip),
    .ready_in  (bus.op2_ready),
    .data_out  (bus.op2),
    .valid_out (bus.op2_valid)
  );

  out_slot #(.WIDTH(WIDTH)) u_slot3 (
    .clock     (clock),
    .reset     (reset),
    .load      (accept && (dest == DEST_3)),
    .data_in   (bus.ip),
    .ready_in  (bus.op3_ready),
    .data_out  (bus.op3),
    .valid_out (bus.op3_valid)
  );

  // Count discarded words, holding at the maximum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept && (dest == DEST_NONE) && (drop_count != DROP_MAX)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  a_sel1_load: assert property (@(posedge clock) disable iff (reset)
    (accept && bus.sel1) |=> (bus.op1 == $past(bus.ip)));

  a_hold1: assert property (@(posedge clock) disable iff (reset)
    (bus.op1_valid && !bus.op1_ready) |=> (bus.op1 == $past(bus.op1)));

  a_hold2: assert property (@(posedge clock) disable iff (reset)
    (bus.op2_valid && !bus.op2_ready) |=> (bus.op2 == $past(bus.op2)));

  a_hold3: assert property (@(posedge clock) disable iff (reset)
    (bus.op3_valid && !bus.op3_ready) |=> (bus.op3 == $past(bus.op3)));

endmodule : demux_dist

// File: tb/tb_demux_dist.sv
// Self-checking bench for demux_dist: directed scenarios plus a randomized
// run checked against a slot-level reference model.
module tb_demux_dist;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] drop_count;
  int         checks = 0;
  int         passed = 0;

  demux_dist_if #(.WIDTH(4)) bus ();

  demux_dist #(.WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  // Reference model state: slot contents and drop tally.
  logic [3:0] m_dat [1:3];
  logic       m_val [1:3];
  int         m_drop;

  function automatic int pick_dest(input logic s1, input logic s2, input logic s3);
    if (s1) return 1;
    if (s2) return 2;
    if (s3) return 3;
    return 0;
  endfunction

  function automatic logic rdy_of(input int n);
    case (n)
      1: return bus.op1_ready;
      2: return bus.op2_ready;
      default: return bus.op3_ready;
    endcase
  endfunction

  function automatic logic [3:0] dat_of(input int n);
    case (n)
      1: return bus.op1;
      2: return bus.op2;
      default: return bus.op3;
    endcase
  endfunction

  function automatic logic val_of(input int n);
    case (n)
      1: return bus.op1_valid;
      2: return bus.op2_valid;
      default: return bus.op3_valid;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.ip = '0; bus.ip_valid = 1'b0;
    bus.sel1 = 1'b0; bus.sel2 = 1'b0; bus.sel3 = 1'b0;
    bus.op1_ready = 1'b0; bus.op2_ready = 1'b0; bus.op3_ready = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    checks++; if (bus.op1_valid !== 1'b0) $display("FAIL reset_v1: got %b want 0", bus.op1_valid); else passed++;
    checks++; if (bus.op2_valid !== 1'b0) $display("FAIL reset_v2: got %b want 0", bus.op2_valid); else passed++;
    checks++; if (bus.op3_valid !== 1'b0) $display("FAIL reset_v3: got %b want 0", bus.op3_valid); else passed++;
    checks++; if ({bus.op1, bus.op2, bus.op3} !== 12'h000) $display("FAIL reset_data: got %h want 000", {bus.op1, bus.op2, bus.op3}); else passed++;
    checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else passed++;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ip_ready); else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_route1();
    bus.ip = 4'hA; bus.ip_valid = 1'b1; bus.sel1 = 1'b1; bus.op1_ready = 1'b1;
    #1;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL route1_ready: got %b want 1", bus.ip_ready); else passed++;
    edge_step();
    checks++; if (bus.op1 !== 4'hA) $display("FAIL route1_data: got %h want a", bus.op1); else passed++;
    checks++; if (bus.op1_valid !== 1'b1) $display("FAIL route1_v1: got %b want 1", bus.op1_valid); else passed++;
    checks++; if ({bus.op2_valid, bus.op3_valid} !== 2'b00) $display("FAIL route1_others: got %b want 00", {bus.op2_valid, bus.op3_valid}); else passed++;
    bus.ip_valid = 1'b0;
    edge_step();
    checks++; if (bus.op1_valid !== 1'b0) $display("FAIL route1_drain: got %b want 0", bus.op1_valid); else passed++;
    idle_inputs();
  endtask

  task automatic test_drops();
    int exp;
    idle_inputs();
    bus.ip_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.ip = 4'($urandom);
      exp = (i + 1 > 255) ? 255 : i + 1;
      edge_step();
      checks++; if (drop_count !== 8'(exp)) $display("FAIL drop_count_%0d: got %0d want %0d", i, drop_count, exp); else passed++;
    end
    checks++; if ({bus.op1_valid, bus.op2_valid, bus.op3_valid} !== 3'b000) $display("FAIL drop_valids: got %b want 000", {bus.op1_valid, bus.op2_valid, bus.op3_valid}); else passed++;
    idle_inputs();
  endtask

  task automatic test_priority_stall();
    bus.sel1 = 1'b0; bus.sel2 = 1'b1; bus.sel3 = 1'b1;
    bus.ip = 4'h5; bus.ip_valid = 1'b1;
    #1;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL prio_ready0: got %b want 1", bus.ip_ready); else passed++;
    edge_step();
    checks++; if ({bus.op2_valid, bus.op2} !== 5'h15) $display("FAIL prio_slot2: got %h want 15", {bus.op2_valid, bus.op2}); else passed++;
    checks++; if (bus.op3_valid !== 1'b0) $display("FAIL prio_not3: got %b want 0", bus.op3_valid); else passed++;
    bus.ip = 4'h6;
    #1;
    checks++; if (bus.ip_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", bus.ip_ready); else passed++;
    edge_step();
    checks++; if ({bus.op2_valid, bus.op2} !== 5'h15) $display("FAIL stall_hold: got %h want 15", {bus.op2_valid, bus.op2}); else passed++;
    bus.op2_ready = 1'b1;
    #1;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL unstall_ready: got %b want 1", bus.ip_ready); else passed++;
    edge_step();
    checks++; if ({bus.op2_valid, bus.op2} !== 5'h16) $display("FAIL reload_slot2: got %h want 16", {bus.op2_valid, bus.op2}); else passed++;
    bus.ip_valid = 1'b0; bus.op2_ready = 1'b0;
  endtask

  task automatic test_independent();
    // slot 2 holds 4'h6 and its consumer is stalled
    bus.sel1 = 1'b0; bus.sel2 = 1'b0; bus.sel3 = 1'b1;
    bus.ip = 4'h3; bus.ip_valid = 1'b1; bus.op3_ready = 1'b0;
    #1;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL indep_ready: got %b want 1", bus.ip_ready); else passed++;
    edge_step();
    checks++; if ({bus.op3_valid, bus.op3} !== 5'h13) $display("FAIL indep_slot3: got %h want 13", {bus.op3_valid, bus.op3}); else passed++;
    checks++; if ({bus.op2_valid, bus.op2} !== 5'h16) $display("FAIL indep_slot2: got %h want 16", {bus.op2_valid, bus.op2}); else passed++;
    bus.sel3 = 1'b0; bus.sel2 = 1'b1;
    #1;
    checks++; if (bus.ip_ready !== 1'b0) $display("FAIL retarget2_ready: got %b want 0", bus.ip_ready); else passed++;
    bus.sel1 = 1'b1; bus.ip = 4'h9;
    #1;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL retarget1_ready: got %b want 1", bus.ip_ready); else passed++;
    edge_step();
    checks++; if ({bus.op1_valid, bus.op1} !== 5'h19) $display("FAIL retarget1_load: got %h want 19", {bus.op1_valid, bus.op1}); else passed++;
    bus.ip_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    // all three slots are full here and drop_count is saturated
    checks++; if ({bus.op1_valid, bus.op2_valid, bus.op3_valid} !== 3'b111) $display("FAIL pre_reset_full: got %b want 111", {bus.op1_valid, bus.op2_valid, bus.op3_valid}); else passed++;
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({bus.op1_valid, bus.op2_valid, bus.op3_valid} !== 3'b000) $display("FAIL midrst_valid: got %b want 000", {bus.op1_valid, bus.op2_valid, bus.op3_valid}); else passed++;
    checks++; if ({bus.op1, bus.op2, bus.op3} !== 12'h000) $display("FAIL midrst_data: got %h want 000", {bus.op1, bus.op2, bus.op3}); else passed++;
    checks++; if (drop_count !== 8'd0) $display("FAIL midrst_drop: got %0d want 0", drop_count); else passed++;
    checks++; if (bus.ip_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.ip_ready); else passed++;
    @(posedge clock); #3;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.sel3 = 1'b1; bus.op3_ready = 1'b1; bus.ip_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.ip = 4'(i);
      #1;
      checks++; if (bus.ip_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.ip_ready); else passed++;
      edge_step();
      checks++; if ({bus.op3_valid, bus.op3} !== {1'b1, 4'(i)}) $display("FAIL b2b_op3_%0d: got %h want %h", i, {bus.op3_valid, bus.op3}, {1'b1, 4'(i)}); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int d;
    logic exp_rdy;
    idle_inputs();
    #2; reset = 1'b1; #2; reset = 1'b0;
    for (int n = 1; n <= 3; n++) begin m_dat[n] = '0; m_val[n] = 1'b0; end
    m_drop = 0;
    @(posedge clock); #1;
    for (int c = 0; c < 400; c++) begin
      bus.ip = 4'($urandom);
      bus.ip_valid = ($urandom_range(0, 3) != 0);
      bus.sel1 = ($urandom_range(0, 3) == 0);
      bus.sel2 = ($urandom_range(0, 2) == 0);
      bus.sel3 = ($urandom_range(0, 1) == 0);
      bus.op1_ready = 1'($urandom);
      bus.op2_ready = 1'($urandom);
      bus.op3_ready = 1'($urandom);
      #1;
      d = pick_dest(bus.sel1, bus.sel2, bus.sel3);
      exp_rdy = (d == 0) ? 1'b1 : (!m_val[d] || rdy_of(d));
      checks++; if (bus.ip_ready !== exp_rdy) $display("FAIL rnd_ready_%0d: got %b want %b", c, bus.ip_ready, exp_rdy); else passed++;
      @(posedge clock);
      for (int n = 1; n <= 3; n++) begin
        if (bus.ip_valid && exp_rdy && d == n) begin
          m_dat[n] = bus.ip; m_val[n] = 1'b1;
        end else if (m_val[n] && rdy_of(n)) begin
          m_val[n] = 1'b0;
        end
      end
      if (bus.ip_valid && d == 0 && m_drop < 255) m_drop++;
      #1;
      for (int n = 1; n <= 3; n++) begin
        checks++; if ({val_of(n), dat_of(n)} !== {m_val[n], m_dat[n]}) $display("FAIL rnd_slot%0d_%0d: got %h want %h", n, c, {val_of(n), dat_of(n)}, {m_val[n], m_dat[n]}); else passed++;
      end
      checks++; if (drop_count !== 8'(m_drop)) $display("FAIL rnd_drop_%0d: got %0d want %0d", c, drop_count, m_drop); else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_route1();
    test_drops();
    test_priority_stall();
    test_independent();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_demux_dist
